burst_ram: RTL
==============

BURST_RAM -- requirements
Module: burst_ram

Interface
REQ-001 SHALL have parameter DEPTH_BITWIDTH, default 12, meaning log2 of the number of stored 64-bit words.
REQ-002 SHALL have parameter ADDRESS_BITWIDTH, default 21, meaning the width of br_addr.
REQ-003 SHALL have parameter ADDRESSING_MODE, default 0, meaning the RAM word size of br_addr (0: 8-bit, 1: 16-bit, 2: 32-bit, 3: 64-bit); word index = br_addr >> (3 - ADDRESSING_MODE).
REQ-004 SHALL have parameter READ_LATENCY, default 8, meaning cycles from the accepted read command to the first valid beat (minimum 1).
REQ-005 SHALL have parameter COMMAND_INTERVAL, default 20, meaning the minimum cycles between accepted commands.
REQ-006 SHALL have parameter INIT_CYCLES, default 16, meaning calibration delay after reset.
REQ-007 SHALL have port clk, input, 1 bit: the single clock.
REQ-008 SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-009 SHALL have port br_cmd, input, 1 bit: 0 read, 1 write.
REQ-010 SHALL have port br_cmd_en, input, 1 bit: command and address valid this cycle.
REQ-011 SHALL have port br_addr, input, ADDRESS_BITWIDTH bits: burst start address.
REQ-012 SHALL have port br_wr_data, input, 64 bits: write beat data.
REQ-013 SHALL have port br_data_mask, input, 8 bits: per-byte write mask, 1 = byte not written.
REQ-014 SHALL have port br_rd_data, output, 64 bits: read beat data.
REQ-015 SHALL have port br_rd_data_valid, output, 1 bit: br_rd_data valid.
REQ-016 SHALL have port init_calib, output, 1 bit: ready for commands.
REQ-017 SHALL have port protocol_error, output, 1 bit: sticky command-violation flag.

Function
REQ-018 SHALL implement states INIT, IDLE, READ_WAIT, READ_BURST and WRITE_BURST; a burst SHALL be 4 beats of 64 bits, addressing words w, w+1, w+2, w+3 modulo 2^DEPTH_BITWIDTH, where w = word index mod 2^DEPTH_BITWIDTH.
REQ-019 INIT SHALL count INIT_CYCLES cycles, then raise init_calib and enter IDLE; init_calib SHALL stay high until reset.
REQ-020 A command SHALL be accepted only when state = IDLE, br_cmd_en = 1 and the interval counter = 0; acceptance SHALL load the counter with COMMAND_INTERVAL, and the counter SHALL decrement to 0 every cycle independently of the state.
REQ-021 Write acceptance SHALL store beat 0 from br_wr_data in the same cycle; WRITE_BURST SHALL store beats 1..3 on the next 3 cycles, then return to IDLE; each byte SHALL be written only where its mask bit is 0.
REQ-022 Read acceptance SHALL enter READ_WAIT; br_rd_data_valid SHALL rise exactly READ_LATENCY cycles after the acceptance edge and stay high for exactly 4 consecutive cycles carrying words w..w+3 in order; the block SHALL then return to IDLE.
REQ-023 A read of a word written by an earlier, completed write burst SHALL return the written data.
REQ-024 br_cmd_en asserted while not accepted (INIT, a burst in progress, or counter ≠ 0) SHALL be ignored with no memory or output effect.
REQ-025 br_rd_data SHALL hold its last value when br_rd_data_valid = 0.
REQ-026 Memory contents SHALL NOT be cleared by reset.

Reset
REQ-027 rst SHALL take effect on the clock edge at any time, including mid-burst, and SHALL abort any burst (remaining write beats are not stored).
REQ-028 On reset: state = INIT, init_calib = 0, br_rd_data_valid = 0, br_rd_data = 0, interval counter = 0, protocol_error = 0.

Configuration
REQ-029 With macro BURST_RAM_PROTOCOL_CHECK_EN defined, protocol_error SHALL set one cycle after any ignored br_cmd_en (REQ-024) and stay set until reset; without the macro, protocol_error SHALL be constant 0 and no check logic SHALL be present.

Structure
REQ-030 A shared package SHALL hold the state enum, the burst beat count (4), the beat width (64) and the command encodings (read 0, write 1).
REQ-031 The word store SHALL be one sub-module, burst_ram_mem: a byte-enabled 64-bit single-clock RAM with one read port and one write port.

Verification
REQ-032 Reset, then idle -> init_calib = 0 for 16 cycles, 1 afterwards; br_rd_data_valid = 0 throughout.
REQ-033 Write at addr 0x40 (mode 0, word 8) of beats 0x1111..., 0x2222..., 0x3333..., 0x4444... with mask 0; read 0x40 after 20 cycles -> valid high exactly 8 cycles after acceptance for 4 cycles with the same 4 words.
REQ-034 Write word 8 with mask 0xF0, data 0xAAAA_AAAA_BBBB_BBBB over stored 0 -> read returns 0x0000_0000_BBBB_BBBB.
REQ-035 Second br_cmd_en 5 cycles after an accepted command -> ignored, memory unchanged, protocol_error = 1 with the macro and 0 without it.
REQ-036 Write burst at word 2^12-2 -> beats stored in words 4094, 4095, 0 and 1 (wrap).
REQ-037 rst asserted during beat 2 of a write burst -> beats 2 and 3 not stored, outputs at reset values, init sequence restarts.

Source files
------------

// File: rtl/burst_ram_pkg.sv
// Shared definitions for the burst RAM: FSM state encoding, burst geometry
// and command encodings.
package burst_ram_pkg;

    typedef enum logic [2:0] {
        ST_INIT        = 3'd0,
        ST_IDLE        = 3'd1,
        ST_READ_WAIT   = 3'd2,
        ST_READ_BURST  = 3'd3,
        ST_WRITE_BURST = 3'd4
    } state_e;

    localparam int BURST_BEATS = 4;
    localparam int BEAT_WIDTH  = 64;
    localparam int BEAT_BYTES  = BEAT_WIDTH / 8;

    localparam logic CMD_READ  = 1'b0;
    localparam logic CMD_WRITE = 1'b1;

    // The external mask marks bytes to skip; the RAM wants byte enables.
    function automatic logic [BEAT_BYTES-1:0] mask_to_be(input logic [BEAT_BYTES-1:0] mask);
        return ~mask;
    endfunction

endpackage

// File: rtl/burst_ram_mem.sv
// Byte-enabled 64-bit single-clock RAM, one write port and one registered
// read port; contents are never cleared, only the read register resets.
module burst_ram_mem
    import burst_ram_pkg::*;
#(
    parameter int DEPTH_BITWIDTH = 12
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_we,
    input  logic [DEPTH_BITWIDTH-1:0] i_waddr,
    input  logic [BEAT_WIDTH-1:0]     i_wdata,
    input  logic [BEAT_BYTES-1:0]     i_wbe,
    input  logic                      i_re,
    input  logic [DEPTH_BITWIDTH-1:0] i_raddr,
    output logic [BEAT_WIDTH-1:0]     o_rdata
);

    logic [BEAT_WIDTH-1:0] r_mem [2**DEPTH_BITWIDTH];
    logic [BEAT_WIDTH-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int b = 0; b < BEAT_BYTES; b++) begin
                if (i_wbe[b]) begin
                    r_mem[i_waddr][b*8 +: 8] <= i_wdata[b*8 +: 8];
                end
            end
        end
    end

    // Read register holds its value between bursts.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/burst_ram.sv
// Burst RAM controller: 4-beat read/write bursts, command spacing and init delay.
// Optional macro BURST_RAM_PROTOCOL_CHECK_EN enables the sticky protocol_error flag.
module burst_ram
    import burst_ram_pkg::*;
#(
    parameter int DEPTH_BITWIDTH   = 12,
    parameter int ADDRESS_BITWIDTH = 21,
    parameter int ADDRESSING_MODE  = 0,
    parameter int READ_LATENCY     = 8,
    parameter int COMMAND_INTERVAL = 20,
    parameter int INIT_CYCLES      = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        br_cmd,
    input  logic                        br_cmd_en,
    input  logic [ADDRESS_BITWIDTH-1:0] br_addr,
    input  logic [63:0]                 br_wr_data,
    input  logic [7:0]                  br_data_mask,
    output logic [63:0]                 br_rd_data,
    output logic                        br_rd_data_valid,
    output logic                        init_calib,
    output logic                        protocol_error,
    output logic [2:0]                  o_dbg_state
);

    localparam logic [2:0] S_INIT        = ST_INIT;
    localparam logic [2:0] S_IDLE        = ST_IDLE;
    localparam logic [2:0] S_READ_WAIT   = ST_READ_WAIT;
    localparam logic [2:0] S_READ_BURST  = ST_READ_BURST;
    localparam logic [2:0] S_WRITE_BURST = ST_WRITE_BURST;

    localparam int ADDR_SHIFT = 3 - ADDRESSING_MODE;
    localparam int CNT_W      = $clog2(COMMAND_INTERVAL + 2);
    localparam int INIT_W     = $clog2(INIT_CYCLES + 2);
    localparam int WAIT_W     = $clog2(READ_LATENCY + 2);

    logic [2:0]                r_state;
    logic [INIT_W-1:0]         r_init_cnt;
    logic                      r_calib;
    logic [CNT_W-1:0]          r_interval;
    logic [WAIT_W-1:0]         r_wait;
    logic [1:0]                r_beat;
    logic [DEPTH_BITWIDTH-1:0] r_base;
    logic                      r_valid;

    logic [DEPTH_BITWIDTH-1:0] w_word;
    logic [DEPTH_BITWIDTH-1:0] w_burst_addr;
    logic                      w_accept;
    logic                      w_acc_wr;
    logic                      w_last_beat;
    logic                      w_we;
    logic                      w_re;
    logic [DEPTH_BITWIDTH-1:0] w_waddr;
    logic [63:0]               w_rdata;

    // A command is taken only in IDLE with the spacing counter expired;
    // there is no back-pressure, so anything else on br_cmd_en is dropped.
    assign w_word       = DEPTH_BITWIDTH'(br_addr >> ADDR_SHIFT);
    assign w_accept     = (r_state == S_IDLE) && br_cmd_en && (r_interval == '0);
    assign w_acc_wr     = w_accept && (br_cmd == CMD_WRITE);
    assign w_burst_addr = r_base + DEPTH_BITWIDTH'(r_beat);
    assign w_last_beat  = (r_beat == 2'(BURST_BEATS - 1));

    // Beat 0 of a write lands on the acceptance edge; reset blocks any beat.
    assign w_we    = !rst && (w_acc_wr || (r_state == S_WRITE_BURST));
    assign w_waddr = w_acc_wr ? w_word : w_burst_addr;
    assign w_re    = !rst && (r_state == S_READ_BURST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_INIT;
            r_init_cnt <= '0;
            r_calib    <= 1'b0;
            r_interval <= '0;
            r_wait     <= '0;
            r_beat     <= '0;
            r_base     <= '0;
            r_valid    <= 1'b0;
        end else begin
            r_valid <= (r_state == S_READ_BURST);

            if (w_accept) begin
                r_interval <= CNT_W'(COMMAND_INTERVAL);
            end else if (r_interval != '0) begin
                r_interval <= r_interval - 1'b1;
            end

            case (r_state)
                S_INIT: begin
                    if (INIT_W'(r_init_cnt + 1'b1) >= INIT_W'(INIT_CYCLES)) begin
                        r_state <= S_IDLE;
                        r_calib <= 1'b1;
                    end else begin
                        r_init_cnt <= r_init_cnt + 1'b1;
                    end
                end
                S_IDLE: begin
                    if (w_accept) begin
                        r_base <= w_word;
                        if (br_cmd == CMD_WRITE) begin
                            r_state <= S_WRITE_BURST;
                            r_beat  <= 2'd1;
                        end else begin
                            r_beat <= 2'd0;
                            // READ_WAIT absorbs all but the last latency cycle.
                            if (READ_LATENCY <= 1) begin
                                r_state <= S_READ_BURST;
                            end else begin
                                r_state <= S_READ_WAIT;
                                r_wait  <= WAIT_W'(READ_LATENCY - 2);
                            end
                        end
                    end
                end
                S_READ_WAIT: begin
                    if (r_wait == '0) begin
                        r_state <= S_READ_BURST;
                    end else begin
                        r_wait <= r_wait - 1'b1;
                    end
                end
                S_READ_BURST, S_WRITE_BURST: begin
                    r_beat <= r_beat + 1'b1;
                    if (w_last_beat) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_INIT;
            endcase
        end
    end

`ifdef BURST_RAM_PROTOCOL_CHECK_EN
    logic r_perr;
    logic w_ignored;

    assign w_ignored = br_cmd_en && !w_accept;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perr <= 1'b0;
        end else if (w_ignored) begin
            r_perr <= 1'b1;
        end
    end

    assign protocol_error = r_perr;
`else
    assign protocol_error = 1'b0;
`endif

    burst_ram_mem #(
        .DEPTH_BITWIDTH(DEPTH_BITWIDTH)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (br_wr_data),
        .i_wbe   (mask_to_be(br_data_mask)),
        .i_re    (w_re),
        .i_raddr (w_burst_addr),
        .o_rdata (w_rdata)
    );

    assign br_rd_data       = w_rdata;
    assign br_rd_data_valid = r_valid;
    assign init_calib       = r_calib;
    assign o_dbg_state      = r_state;

endmodule
